// File: rtl/multi_toggle_rx.sv
// multi_toggle_rx
// Receives N independent toggle-encoded event lines from a foreign clock
// domain. Each channel synchronises its line, turns every level change
// into a one-cycle pulse, and accumulates pulses in a saturating
// pending-event counter. A consumer pops events one at a time. A sticky
// flag records any event that arrived while the counter was already full.
//
// Ports
//   clk        : single clock, all flops rising-edge
//   rst_n      : asynchronous active-low reset
//   tog_in     : [N] asynchronous toggle lines, one event per level change
//   evt_pop    : [N] consume one pending event (ignored when count is 0)
//   ovf_clr    : [N] clear the sticky overflow flag
//   evt_pulse  : [N] one-cycle pulse per detected toggle
//   evt_valid  : [N] pending count nonzero
//   evt_cnt    : [N*CW] pending counts, channel i at [i*CW +: CW]
//   evt_ovf    : [N] sticky overflow flags
//   any_valid  : OR of evt_valid
module multi_toggle_rx #(
    parameter int N      = 4,
    parameter int STAGES = 2,
    parameter int CW     = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    tog_in,
    input  logic [N-1:0]    evt_pop,
    input  logic [N-1:0]    ovf_clr,
    output logic [N-1:0]    evt_pulse,
    output logic [N-1:0]    evt_valid,
    output logic [N*CW-1:0] evt_cnt,
    output logic [N-1:0]    evt_ovf,
    output logic            any_valid
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [STAGES-1:0] sync_q;
        logic              hist_q;
        logic [CW-1:0]     cnt_q;
        logic              ovf_q;
        logic              pulse;
        logic              pop_eff;
        logic              at_max;

        assign pulse   = sync_q[STAGES-1] ^ hist_q;
        assign pop_eff = evt_pop[i] && (cnt_q != '0);
        assign at_max  = &cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
                hist_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[STAGES-2:0], tog_in[i]};
                hist_q <= sync_q[STAGES-1];
            end
        end

        // A pulse and an effective pop cancel, so a full counter that is
        // being drained at the same rate never reports overflow.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (pulse && !pop_eff) begin
                    if (!at_max) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end else if (!pulse && pop_eff) begin
                    cnt_q <= cnt_q - CNT_ONE;
                end

                // set wins over clear on the same edge
                if (pulse && !pop_eff && at_max) begin
                    ovf_q <= 1'b1;
                end else if (ovf_clr[i]) begin
                    ovf_q <= 1'b0;
                end
            end
        end

        assign evt_pulse[i]         = pulse;
        assign evt_valid[i]         = (cnt_q != '0);
        assign evt_cnt[i*CW +: CW]  = cnt_q;
        assign evt_ovf[i]           = ovf_q;
    end

    assign any_valid = |evt_valid;

endmodule

// File: tb/tb_multi_toggle_rx.sv
module tb_multi_toggle_rx;

    logic        clk;
    logic        rst_n;
    logic [3:0]  tog;
    logic [3:0]  pop;
    logic [3:0]  clr;
    logic [3:0]  pulse;
    logic [3:0]  valid;
    logic [11:0] cnt;
    logic [3:0]  ovf;
    logic        anyv;

    logic [3:0]  tog3;
    logic [3:0]  pop3;
    logic [3:0]  clr3;
    logic [3:0]  pulse3;
    logic [3:0]  valid3;
    logic [11:0] cnt3;
    logic [3:0]  ovf3;
    logic        anyv3;

    int checks;
    int failures;

    multi_toggle_rx #(.N(4), .STAGES(2), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n), .tog_in(tog), .evt_pop(pop), .ovf_clr(clr),
        .evt_pulse(pulse), .evt_valid(valid), .evt_cnt(cnt), .evt_ovf(ovf),
        .any_valid(anyv)
    );

    multi_toggle_rx #(.N(4), .STAGES(3), .CW(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .tog_in(tog3), .evt_pop(pop3), .ovf_clr(clr3),
        .evt_pulse(pulse3), .evt_valid(valid3), .evt_cnt(cnt3), .evt_ovf(ovf3),
        .any_valid(anyv3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tog;
        logic [3:0]  pop;
        logic [3:0]  clr;
        logic [3:0]  pulse;
        logic [11:0] cnt;
        logic [3:0]  valid;
        logic [3:0]  ovf;
    } vec_t;

    vec_t vecs [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // flip the masked lines, then hold long enough for the event to be counted
    task automatic tgl(input logic [3:0] mask);
        tog = tog ^ mask;
        repeat (4) step();
    endtask

    initial begin
        logic [3:0] seen;
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        tog = '0; pop = '0; clr = '0;
        tog3 = '0; pop3 = '0; clr3 = '0;

        //              tog    pop    clr    pulse  cnt      valid  ovf
        vecs[0]  = '{4'h1, 4'h0, 4'h0, 4'h0, 12'h000, 4'h0, 4'h0};
        vecs[1]  = '{4'h1, 4'h0, 4'h0, 4'h1, 12'h000, 4'h0, 4'h0};
        vecs[2]  = '{4'h1, 4'h0, 4'h0, 4'h0, 12'h001, 4'h1, 4'h0};
        vecs[3]  = '{4'h3, 4'h1, 4'h0, 4'h0, 12'h000, 4'h0, 4'h0};
        vecs[4]  = '{4'h3, 4'h0, 4'h0, 4'h2, 12'h000, 4'h0, 4'h0};
        vecs[5]  = '{4'h3, 4'h2, 4'h0, 4'h0, 12'h008, 4'h2, 4'h0};
        vecs[6]  = '{4'h2, 4'h0, 4'h0, 4'h0, 12'h008, 4'h2, 4'h0};
        vecs[7]  = '{4'h2, 4'h0, 4'h0, 4'h1, 12'h008, 4'h2, 4'h0};
        vecs[8]  = '{4'h2, 4'h1, 4'h0, 4'h0, 12'h009, 4'h3, 4'h0};
        vecs[9]  = '{4'h2, 4'h3, 4'h0, 4'h0, 12'h000, 4'h0, 4'h0};
        vecs[10] = '{4'h2, 4'hF, 4'hF, 4'h0, 12'h000, 4'h0, 4'h0};

        // reset state with clock running
        repeat (2) step();
        chk("rst_pulse", {28'd0, pulse}, 32'h0);
        chk("rst_cnt",   {20'd0, cnt},   32'h0);
        chk("rst_valid", {28'd0, valid}, 32'h0);
        chk("rst_ovf",   {28'd0, ovf},   32'h0);
        chk("rst_any",   {31'd0, anyv},  32'h0);
        rst_n = 1'b1;

        // table: inputs before edge r+1, outputs checked just after it
        for (int r = 0; r < 11; r++) begin
            tog = vecs[r].tog;
            pop = vecs[r].pop;
            clr = vecs[r].clr;
            step();
            chk($sformatf("vec%0d_pulse", r), {28'd0, pulse}, {28'd0, vecs[r].pulse});
            chk($sformatf("vec%0d_cnt", r),   {20'd0, cnt},   {20'd0, vecs[r].cnt});
            chk($sformatf("vec%0d_valid", r), {28'd0, valid}, {28'd0, vecs[r].valid});
            chk($sformatf("vec%0d_ovf", r),   {28'd0, ovf},   {28'd0, vecs[r].ovf});
            chk($sformatf("vec%0d_any", r),   {31'd0, anyv},  {31'd0, (vecs[r].valid != 4'h0)});
        end
        pop = '0;
        clr = '0;

        // ch1 saturation: 7 events fill, 8th overflows and holds
        repeat (7) tgl(4'h2);
        chk("ch1_cnt7",   {29'd0, cnt[5:3]}, 32'd7);
        chk("ch1_noovf",  {31'd0, ovf[1]},   32'd0);
        tgl(4'h2);
        chk("ch1_sat",    {29'd0, cnt[5:3]}, 32'd7);
        chk("ch1_ovf",    {31'd0, ovf[1]},   32'd1);
        clr = 4'h2;
        step();
        clr = '0;
        chk("ch1_ovfclr", {31'd0, ovf[1]},   32'd0);
        chk("ch1_keep",   {29'd0, cnt[5:3]}, 32'd7);

        // ch2 full, pulse coincides with effective pop
        repeat (7) tgl(4'h4);
        chk("ch2_cnt7", {29'd0, cnt[8:6]}, 32'd7);
        tog = tog ^ 4'h4;
        repeat (2) step();
        chk("ch2_pulse", {31'd0, pulse[2]}, 32'd1);
        pop = 4'h4;
        step();
        pop = '0;
        chk("ch2_popcoinc_cnt", {29'd0, cnt[8:6]}, 32'd7);
        chk("ch2_popcoinc_ovf", {31'd0, ovf[2]},   32'd0);
        chk("ch2_pulse_gone",   {31'd0, pulse[2]}, 32'd0);
        step();

        // ch3 overflow, then clear collides with a new overflow
        repeat (8) tgl(4'h8);
        chk("ch3_cnt7", {29'd0, cnt[11:9]}, 32'd7);
        chk("ch3_ovf",  {31'd0, ovf[3]},    32'd1);
        tog = tog ^ 4'h8;
        repeat (2) step();
        clr = 4'h8;
        step();
        clr = '0;
        chk("ch3_setwins", {31'd0, ovf[3]}, 32'd1);
        step();
        clr = 4'h8;
        step();
        clr = '0;
        chk("ch3_clr", {31'd0, ovf[3]}, 32'd0);

        // clean restart, build counts 5,2,0,7
        rst_n = 1'b0;
        tog = '0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tgl({1'b1, 1'b0, (i < 2) ? 1'b1 : 1'b0, (i < 5) ? 1'b1 : 1'b0});
        end
        chk("pre_rst_cnt", {20'd0, cnt}, 32'hE15);
        tog = tog ^ 4'h1;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt",   {20'd0, cnt},   32'h0);
        chk("async_rst_valid", {28'd0, valid}, 32'h0);
        chk("async_rst_pulse", {28'd0, pulse}, 32'h0);
        chk("async_rst_ovf",   {28'd0, ovf},   32'h0);
        chk("async_rst_any",   {31'd0, anyv},  32'h0);
        tog = '0;
        repeat (2) step();
        rst_n = 1'b1;
        seen = '0;
        repeat (6) begin
            step();
            seen = seen | pulse;
        end
        chk("rel_no_pulse", {28'd0, seen}, 32'h0);
        chk("rel_cnt",      {20'd0, cnt},  32'h0);

        // line already high at reset release yields exactly one event
        rst_n = 1'b0;
        tog = 4'h1;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (8) step();
        chk("rel_high_cnt", {20'd0, cnt}, 32'h001);

        // STAGES=3 instance: all channels together, pulses 3 edges later
        tog3 = 4'hF;
        step();
        chk("s3_e0", {28'd0, pulse3}, 32'h0);
        step();
        chk("s3_e1", {28'd0, pulse3}, 32'h0);
        step();
        chk("s3_e2", {28'd0, pulse3}, 32'hF);
        step();
        chk("s3_e3",   {28'd0, pulse3}, 32'h0);
        chk("s3_cnt",  {20'd0, cnt3},   32'h249);
        chk("s3_any",  {31'd0, anyv3},  32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_toggle_rx.md
MULTI_TOGGLE_RX -- requirements
Module: multi_toggle_rx

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of independent toggle channels (1..32).
REQ-002 The block SHALL have parameter STAGES, default 2, giving the synchroniser depth per channel (2..4).
REQ-003 The block SHALL have parameter CW, default 3, giving the pending-event counter width per channel (1..8).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge clk.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port tog_in, input, N bits: asynchronous toggle lines from foreign-domain toggle flops; each level change is one event.
REQ-007 The block SHALL have port evt_pop, input, N bits: per-channel consume request.
REQ-008 The block SHALL have port ovf_clr, input, N bits: per-channel overflow-flag clear.
REQ-009 The block SHALL have port evt_pulse, output, N bits: one-cycle event pulse per detected toggle.
REQ-010 The block SHALL have port evt_valid, output, N bits: high while the channel's pending count is nonzero.
REQ-011 The block SHALL have port evt_cnt, output, N*CW bits: pending count, with channel i at bits [i*CW +: CW].
REQ-012 The block SHALL have port evt_ovf, output, N bits: sticky overflow flag.
REQ-013 The block SHALL have port any_valid, output, 1 bit: OR of evt_valid.

Function
REQ-014 Each channel SHALL pass tog_in[i] through a chain of STAGES flops (sync[0] samples tog_in[i]), then through one edge-history flop (hist) that samples sync[STAGES-1].
REQ-015 evt_pulse[i] SHALL be combinational sync[STAGES-1] XOR hist: high for exactly one clk cycle per tog_in[i] level change.
REQ-016 Latency SHALL be fixed: a tog_in change meeting setup before edge k makes evt_pulse high during the cycle after edge k+STAGES-1 and low after edge k+STAGES.
REQ-017 Toggles spaced closer than STAGES+1 clk periods SHALL NOT be guaranteed to be resolved; the source shall hold each level for at least STAGES+1 clk periods.
REQ-018 On each clk edge, with evt_pulse[i]=1 and the pop not effective, the count SHALL increment by 1 if below 2^CW-1.
REQ-019 A pop SHALL be effective only when evt_pop[i]=1 and the count is nonzero; a pop with count=0 SHALL be ignored without error.
REQ-020 An effective pop with evt_pulse[i]=0 SHALL decrement the count by 1.
REQ-021 evt_pulse[i]=1 together with an effective pop SHALL leave the count unchanged and SHALL NOT set overflow, including at the maximum count.
REQ-022 evt_pulse[i]=1 at count 2^CW-1 with no effective pop SHALL hold the count (no wrap) and set evt_ovf[i] on that edge.
REQ-023 evt_ovf[i] SHALL clear on the edge where ovf_clr[i]=1, unless a new overflow occurs on the same edge; in that case set wins.
REQ-024 evt_valid[i] SHALL be a registered-state decode (count != 0), so it is valid in the cycle after the increment edge.
REQ-025 Channels SHALL be fully independent; no cross-channel arbitration or priority SHALL exist.

Reset
REQ-026 While rst_n=0, all sync, hist, count and overflow flops SHALL be 0, regardless of clk.
REQ-027 While rst_n=0, evt_pulse, evt_valid, evt_cnt, evt_ovf and any_valid SHALL be 0.
REQ-028 Reset release SHALL take effect on the first clk edge after rst_n rises.
REQ-029 If tog_in[i]=1 at reset release, exactly one event SHALL be generated on that channel; the source toggle flops shall reset to 0 on the same reset.
REQ-030 Reset asserted mid-operation SHALL discard all pending counts and in-flight toggles immediately.

Verification
REQ-031 Scenario: N=4, STAGES=2; tog_in[0] 0->1 before edge 1 -> evt_pulse[0]=1 only between edges 2 and 3; evt_cnt[0]=1 and evt_valid[0]=1 after edge 3.
REQ-032 Scenario: CW=3; 8 toggles on ch1 spaced 4 cycles, no pops -> count reaches 7, 8th pulse sets evt_ovf[1], count stays 7.
REQ-033 Scenario: ch2 count=7, evt_pulse and evt_pop coincide -> count stays 7, evt_ovf[2] stays 0.
REQ-034 Scenario: evt_pop[3]=1 with count 0 -> count stays 0; then ovf_clr together with a new overflow -> evt_ovf stays 1.
REQ-035 Scenario: STAGES=3; all 4 channels toggle on the same edge -> all 4 pulses appear together 3 edges later; any_valid=1.
REQ-036 Scenario: rst_n pulled low mid-count (counts 5,2,0,7) -> all outputs 0 asynchronously; tog_in=0 at release gives no events.
